// File: rtl/ex_mem_pipeline_reg_if.sv
// EX/MEM pipeline register bus: EX-stage inputs, MEM-side stall/flush,
// the upstream stall and the registered MEM-stage outputs.
interface ex_mem_pipeline_reg_if;
  logic        ex_valid;
  logic [4:0]  ex_alu_select;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write_en;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_func3;
  logic        mem_stall;
  logic        flush;
  logic        ex_stall;
  logic        mem_valid;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_rs2_data;
  logic [4:0]  mem_rd_addr;
  logic        mem_reg_write_en;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [2:0]  mem_func3;

  // Pipeline side: drives the EX stage and MEM-side controls.
  modport master (
    output ex_valid, ex_alu_select, ex_alu_result, ex_rs2_data, ex_rd_addr,
           ex_reg_write_en, ex_mem_read, ex_mem_write, ex_func3,
           mem_stall, flush,
    input  ex_stall, mem_valid, mem_alu_result, mem_rs2_data, mem_rd_addr,
           mem_reg_write_en, mem_mem_read, mem_mem_write, mem_func3
  );

  // Register side.
  modport slave (
    input  ex_valid, ex_alu_select, ex_alu_result, ex_rs2_data, ex_rd_addr,
           ex_reg_write_en, ex_mem_read, ex_mem_write, ex_func3,
           mem_stall, flush,
    output ex_stall, mem_valid, mem_alu_result, mem_rs2_data, mem_rd_addr,
           mem_reg_write_en, mem_mem_read, mem_mem_write, mem_func3
  );
endinterface

// File: rtl/ex_mem_pipeline_reg.sv
// EX/MEM pipeline register with multi-cycle hold for M-extension ops.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_PASS | normal flow; an M op seen here starts the hold
// ST_WAIT | M op held in EX; cnt counts remaining stall cycles
//
// M-extension op codes: MUL=16 MULH=17 MULHSU=18 MULHU=19
//                       DIV=20 DIVU=21 REM=22 REMU=23
module ex_mem_pipeline_reg #(
  parameter int unsigned MD_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  ex_mem_pipeline_reg_if.slave   bus
);

  localparam logic [4:0] ALU_MUL    = 5'd16;
  localparam logic [4:0] ALU_MULH   = 5'd17;
  localparam logic [4:0] ALU_MULHSU = 5'd18;
  localparam logic [4:0] ALU_MULHU  = 5'd19;
  localparam logic [4:0] ALU_DIV    = 5'd20;
  localparam logic [4:0] ALU_DIVU   = 5'd21;
  localparam logic [4:0] ALU_REM    = 5'd22;
  localparam logic [4:0] ALU_REMU   = 5'd23;

  localparam logic       MD_EN   = (MD_CYCLES != 0);
  localparam logic [3:0] MD_LAST = (MD_CYCLES == 0) ? 4'd0 : 4'(MD_CYCLES - 1);

  typedef enum logic {ST_PASS, ST_WAIT} state_t;
  typedef enum logic [1:0] {ACT_HOLD, ACT_LOAD, ACT_BUBBLE} act_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  act_t        act;
  logic        is_md;
  logic        md_start;

  logic        valid_q;
  logic [31:0] alu_result_q;
  logic [31:0] rs2_data_q;
  logic [4:0]  rd_addr_q;
  logic        reg_write_en_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [2:0]  func3_q;

  // Decode M-extension ops.
  always_comb begin
    is_md = 1'b0;
    case (bus.ex_alu_select)
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: is_md = 1'b1;
      default: is_md = 1'b0;
    endcase
  end

  assign md_start = (state == ST_PASS) & bus.ex_valid & is_md & MD_EN;

  // Upstream stall; forced low while reset is asserted.
  assign bus.ex_stall = reset & (bus.mem_stall |
                        (~bus.flush & (md_start | ((state == ST_WAIT) & (cnt != 4'd0)))));

  // Next state, counter and MEM register action, in priority order.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    act       = ACT_HOLD;
    if (bus.mem_stall) begin
      if (bus.flush) begin
        state_nxt = ST_PASS;
        cnt_nxt   = 4'd0;
      end
    end else if (bus.flush) begin
      act       = ACT_BUBBLE;
      state_nxt = ST_PASS;
      cnt_nxt   = 4'd0;
    end else if (state == ST_PASS) begin
      if (md_start) begin
        act       = ACT_BUBBLE;
        cnt_nxt   = MD_LAST;
        state_nxt = ST_WAIT;
      end else begin
        act = ACT_LOAD;
      end
    end else if (cnt != 4'd0) begin
      act     = ACT_BUBBLE;
      cnt_nxt = cnt - 4'd1;
    end else begin
      act       = ACT_LOAD;
      state_nxt = ST_PASS;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_PASS;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // MEM-stage register: load, bubble (data kept) or hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= 1'b0;
      alu_result_q   <= 32'd0;
      rs2_data_q     <= 32'd0;
      rd_addr_q      <= 5'd0;
      reg_write_en_q <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      func3_q        <= 3'd0;
    end else begin
      case (act)
        ACT_LOAD: begin
          valid_q        <= bus.ex_valid;
          reg_write_en_q <= bus.ex_reg_write_en & bus.ex_valid;
          mem_read_q     <= bus.ex_mem_read & bus.ex_valid;
          mem_write_q    <= bus.ex_mem_write & bus.ex_valid;
          alu_result_q   <= bus.ex_alu_result;
          rs2_data_q     <= bus.ex_rs2_data;
          rd_addr_q      <= bus.ex_rd_addr;
          func3_q        <= bus.ex_func3;
        end
        ACT_BUBBLE: begin
          valid_q        <= 1'b0;
          reg_write_en_q <= 1'b0;
          mem_read_q     <= 1'b0;
          mem_write_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_valid        = valid_q;
  assign bus.mem_alu_result   = alu_result_q;
  assign bus.mem_rs2_data     = rs2_data_q;
  assign bus.mem_rd_addr      = rd_addr_q;
  assign bus.mem_reg_write_en = reg_write_en_q;
  assign bus.mem_mem_read     = mem_read_q;
  assign bus.mem_mem_write    = mem_write_q;
  assign bus.mem_func3        = func3_q;

endmodule

// File: tb/tb_ex_mem_pipeline_reg.sv
// Directed bench for ex_mem_pipeline_reg: a sequential vector table run
// on an MD_CYCLES=2 instance, plus async-reset and MD_CYCLES=0 sequences.
module tb_ex_mem_pipeline_reg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd19;
  localparam logic [4:0] OP_DIV   = 5'd20;
  localparam logic [4:0] OP_REM   = 5'd22;

  logic clk;
  logic reset;

  logic        ex_valid;
  logic [4:0]  ex_alu_select;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write_en;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_func3;
  logic        mem_stall;
  logic        flush;

  ex_mem_pipeline_reg_if bus ();
  ex_mem_pipeline_reg_if bus0 ();

  assign bus.ex_valid         = ex_valid;
  assign bus.ex_alu_select    = ex_alu_select;
  assign bus.ex_alu_result    = ex_alu_result;
  assign bus.ex_rs2_data      = ex_rs2_data;
  assign bus.ex_rd_addr       = ex_rd_addr;
  assign bus.ex_reg_write_en  = ex_reg_write_en;
  assign bus.ex_mem_read      = ex_mem_read;
  assign bus.ex_mem_write     = ex_mem_write;
  assign bus.ex_func3         = ex_func3;
  assign bus.mem_stall        = mem_stall;
  assign bus.flush            = flush;

  assign bus0.ex_valid        = ex_valid;
  assign bus0.ex_alu_select   = ex_alu_select;
  assign bus0.ex_alu_result   = ex_alu_result;
  assign bus0.ex_rs2_data     = ex_rs2_data;
  assign bus0.ex_rd_addr      = ex_rd_addr;
  assign bus0.ex_reg_write_en = ex_reg_write_en;
  assign bus0.ex_mem_read     = ex_mem_read;
  assign bus0.ex_mem_write    = ex_mem_write;
  assign bus0.ex_func3        = ex_func3;
  assign bus0.mem_stall       = mem_stall;
  assign bus0.flush           = flush;

  ex_mem_pipeline_reg #(.MD_CYCLES(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
  ex_mem_pipeline_reg #(.MD_CYCLES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [4:0]  sel;
    logic [31:0] res;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [2:0]  en;      // {reg_write, mem_read, mem_write}
    logic [2:0]  f3;
    logic        ms;
    logic        fl;
    logic        x_stall;
    logic        x_valid;
    logic [31:0] x_res;
    logic [31:0] x_rs2;
    logic [4:0]  x_rd;
    logic [2:0]  x_en;
    logic [2:0]  x_f3;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic v, logic [4:0] s, logic [31:0] r, logic [31:0] d,
                              logic [4:0] rd, logic [2:0] en, logic [2:0] f3,
                              logic ms, logic fl,
                              logic xs, logic xv, logic [31:0] xr, logic [31:0] xd,
                              logic [4:0] xrd, logic [2:0] xen, logic [2:0] xf3);
    vec_t t;
    t.valid = v;  t.sel = s;  t.res = r;  t.rs2 = d;  t.rd = rd;
    t.en = en;    t.f3 = f3;  t.ms = ms;  t.fl = fl;
    t.x_stall = xs; t.x_valid = xv; t.x_res = xr; t.x_rs2 = xd;
    t.x_rd = xrd;   t.x_en = xen;   t.x_f3 = xf3;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    ex_valid        = t.valid;
    ex_alu_select   = t.sel;
    ex_alu_result   = t.res;
    ex_rs2_data     = t.rs2;
    ex_rd_addr      = t.rd;
    ex_reg_write_en = t.en[2];
    ex_mem_read     = t.en[1];
    ex_mem_write    = t.en[0];
    ex_func3        = t.f3;
    mem_stall       = t.ms;
    flush           = t.fl;
  endtask

  task automatic chk_mem(input string tag, input logic xv, input logic [31:0] xr,
                         input logic [31:0] xd, input logic [4:0] xrd,
                         input logic [2:0] xen, input logic [2:0] xf3);
    chk({tag, " mem_valid"}, {31'd0, bus.mem_valid}, {31'd0, xv});
    chk({tag, " mem_alu_result"}, bus.mem_alu_result, xr);
    chk({tag, " mem_rs2_data"}, bus.mem_rs2_data, xd);
    chk({tag, " mem_rd_addr"}, {27'd0, bus.mem_rd_addr}, {27'd0, xrd});
    chk({tag, " mem_enables"},
        {29'd0, bus.mem_reg_write_en, bus.mem_mem_read, bus.mem_mem_write}, {29'd0, xen});
    chk({tag, " mem_func3"}, {29'd0, bus.mem_func3}, {29'd0, xf3});
  endtask

  initial begin
    vec_t t;
    // valid sel res rs2 rd en f3 ms fl | stall valid res rs2 rd en f3
    vecs.push_back(mk(1, OP_ADD,   32'h10,       0, 5, 3'b100, 0, 0, 0,  0, 1, 32'h10,       0, 5, 3'b100, 0));
    vecs.push_back(mk(1, OP_MUL,   32'hFFFFFFF0, 0, 7, 3'b100, 0, 0, 0,  1, 0, 32'h10,       0, 5, 3'b000, 0));
    vecs.push_back(mk(1, OP_MUL,   32'hFFFFFFF0, 0, 7, 3'b100, 0, 0, 0,  1, 0, 32'h10,       0, 5, 3'b000, 0));
    vecs.push_back(mk(1, OP_MUL,   32'hFFFFFFF0, 0, 7, 3'b100, 0, 0, 0,  0, 1, 32'hFFFFFFF0, 0, 7, 3'b100, 0));
    vecs.push_back(mk(1, OP_MULHU, 32'h1234,     0, 8, 3'b100, 0, 0, 0,  1, 0, 32'hFFFFFFF0, 0, 7, 3'b000, 0));
    vecs.push_back(mk(1, OP_MULHU, 32'h1234,     0, 8, 3'b100, 0, 0, 0,  1, 0, 32'hFFFFFFF0, 0, 7, 3'b000, 0));
    vecs.push_back(mk(1, OP_MULHU, 32'h1234,     0, 8, 3'b100, 0, 0, 0,  0, 1, 32'h1234,     0, 8, 3'b100, 0));
    vecs.push_back(mk(1, OP_DIV,   32'hAAAA,     0, 9, 3'b100, 4, 0, 0,  1, 0, 32'h1234,     0, 8, 3'b000, 0));
    vecs.push_back(mk(1, OP_DIV,   32'hAAAA,     0, 9, 3'b100, 4, 0, 1,  0, 0, 32'h1234,     0, 8, 3'b000, 0));
    vecs.push_back(mk(1, OP_ADD,   32'h20,       0, 4, 3'b100, 0, 0, 0,  0, 1, 32'h20,       0, 4, 3'b100, 0));
    vecs.push_back(mk(0, OP_ADD,   32'h55,       0, 3, 3'b100, 0, 0, 0,  0, 0, 32'h55,       0, 3, 3'b000, 0));
    vecs.push_back(mk(1, OP_ADD,   32'h100, 32'hDEADBEEF, 0, 3'b001, 2, 0, 0,  0, 1, 32'h100, 32'hDEADBEEF, 0, 3'b001, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1, OP_ADD, 32'h77, 32'h11111111, 6, 3'b100, 0, 1, 0,  1, 1, 32'h100, 32'hDEADBEEF, 0, 3'b001, 2));
    vecs.push_back(mk(1, OP_ADD,   32'h77, 32'h11111111, 6, 3'b100, 0, 0, 0,  0, 1, 32'h77, 32'h11111111, 6, 3'b100, 0));
    vecs.push_back(mk(1, OP_ADD,   32'h200,      0, 10, 3'b110, 2, 0, 0, 0, 1, 32'h200,      0, 10, 3'b110, 2));
    vecs.push_back(mk(1, OP_MUL,   32'h3,        0, 12, 3'b100, 0, 1, 0, 1, 1, 32'h200,      0, 10, 3'b110, 2));
    vecs.push_back(mk(1, OP_MUL,   32'h3,        0, 12, 3'b100, 0, 0, 0, 1, 0, 32'h200,      0, 10, 3'b000, 2));
    vecs.push_back(mk(1, OP_MUL,   32'h3,        0, 12, 3'b100, 0, 1, 0, 1, 0, 32'h200,      0, 10, 3'b000, 2));
    vecs.push_back(mk(1, OP_MUL,   32'h3,        0, 12, 3'b100, 0, 0, 0, 1, 0, 32'h200,      0, 10, 3'b000, 2));
    vecs.push_back(mk(1, OP_MUL,   32'h3,        0, 12, 3'b100, 0, 0, 0, 0, 1, 32'h3,        0, 12, 3'b100, 0));
    vecs.push_back(mk(1, OP_MUL,   32'h9,        0, 13, 3'b100, 0, 0, 0, 1, 0, 32'h3,        0, 12, 3'b000, 0));
    vecs.push_back(mk(1, OP_MUL,   32'h9,        0, 13, 3'b100, 0, 1, 1, 1, 0, 32'h3,        0, 12, 3'b000, 0));
    vecs.push_back(mk(0, OP_ADD,   32'h44,       0, 14, 3'b100, 0, 0, 0, 0, 0, 32'h44,       0, 14, 3'b000, 0));
    vecs.push_back(mk(1, OP_ADD,   32'h66,       0, 15, 3'b100, 0, 0, 1, 0, 0, 32'h44,       0, 14, 3'b000, 0));
    vecs.push_back(mk(1, OP_ADD,   32'h66,       0, 15, 3'b100, 0, 0, 0, 0, 1, 32'h66,       0, 15, 3'b100, 0));

    // Reset with a stalling, M-op input pattern: stall must stay low.
    reset = 1'b0;
    drive(mk(1, OP_MUL, 32'h1, 32'h2, 1, 3'b111, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset ex_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk_mem("reset", 0, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk({tag, " ex_stall"}, {31'd0, bus.ex_stall}, {31'd0, vecs[i].x_stall});
      @(posedge clk);
      #1;
      chk_mem(tag, vecs[i].x_valid, vecs[i].x_res, vecs[i].x_rs2, vecs[i].x_rd,
              vecs[i].x_en, vecs[i].x_f3);
    end

    // Async reset while an M op is held in WAIT.
    @(negedge clk);
    t = mk(1, OP_MUL, 32'hABC, 32'h5A5A, 16, 3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(t);
    @(posedge clk);
    #1;
    chk("areset pre valid", {31'd0, bus.mem_valid}, 32'd0);
    chk("areset pre stall", {31'd0, bus.ex_stall}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("areset ex_stall", {31'd0, bus.ex_stall}, 32'd0);
    chk_mem("areset", 0, 0, 0, 0, 3'b000, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("post reset PASS stall", {31'd0, bus.ex_stall}, 32'd1);

    // REM flows through the MD_CYCLES=0 instance with no stall.
    @(negedge clk);
    drive(mk(1, OP_REM, 32'h5, 32'h0, 11, 3'b100, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("md0 rem ex_stall", {31'd0, bus0.ex_stall}, 32'd0);
    @(posedge clk);
    #1;
    chk("md0 rem mem_valid", {31'd0, bus0.mem_valid}, 32'd1);
    chk("md0 rem mem_alu_result", bus0.mem_alu_result, 32'h5);
    chk("md0 rem mem_rd_addr", {27'd0, bus0.mem_rd_addr}, 32'd11);
    chk("md0 rem mem_reg_write_en", {31'd0, bus0.mem_reg_write_en}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipeline_reg.md
# ex_mem_pipeline_reg

EX/MEM pipeline register for the RV32IM pipeline. It sits directly downstream of the EX-stage ALU and captures the ALU result, store data and MEM/WB control for the MEM stage. It also holds multiply/divide instructions in EX for a fixed number of extra cycles, raising a stall to the upstream stages until the result is settled. It honours a MEM-side stall and a branch/jump flush.

## Interface
- MD_CYCLES, default 2: extra cycles an M-extension op is held in EX. Legal range 0..15; 0 means M ops flow like base ops.
- CLK  in  1  pipeline clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- EX_VALID  in  1  the EX stage holds a real instruction.
- EX_ALU_SELECT  in  5  ALU op code, encoded per constants/encordings.v.
- EX_ALU_RESULT  in  32  ALU result.
- EX_RS2_DATA  in  32  forwarded rs2 value (store data).
- EX_RD_ADDR  in  5  destination register.
- EX_REG_WRITE_EN  in  1  writeback enable.
- EX_MEM_READ  in  1  load.
- EX_MEM_WRITE  in  1  store.
- EX_FUNC3  in  3  load/store width and sign.
- MEM_STALL  in  1  MEM stage cannot accept (data memory busy).
- FLUSH  in  1  kill the instruction currently in EX.
- EX_STALL  out  1  freeze PC, IF/ID and ID/EX this cycle.
- MEM_VALID  out  1  MEM-stage instruction valid.
- MEM_ALU_RESULT  out  32  registered result / address.
- MEM_RS2_DATA  out  32  registered store data.
- MEM_RD_ADDR  out  5  registered destination register.
- MEM_REG_WRITE_EN, MEM_MEM_READ, MEM_MEM_WRITE  out  1 each  registered control.
- MEM_FUNC3  out  3  registered func3.

## Operation
- is_md = EX_ALU_SELECT is one of MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- There are two states, PASS and WAIT, plus a down-counter CNT of 4 bits.
- The MEM register has three possible actions:
  - load: MEM_VALID is set to EX_VALID. The write, read and store enables are set to their EX values ANDed with EX_VALID. The data fields are copied.
  - bubble: MEM_VALID and all three enables go to 0. The data fields keep their old values.
  - hold: nothing changes.
- Priority per edge:
  1. MEM_STALL = 1: the MEM register holds. State and CNT hold, except that FLUSH = 1 still forces state to PASS and CNT to 0.
  2. FLUSH = 1: the MEM register takes a bubble. State goes to PASS and CNT to 0.
  3. In PASS, with EX_VALID, is_md and MD_CYCLES != 0: the MEM register takes a bubble, CNT is set to MD_CYCLES-1, and the block moves to WAIT.
  4. In PASS otherwise: the MEM register loads (a bubble if EX_VALID = 0).
  5. In WAIT with CNT != 0: the MEM register takes a bubble and CNT decrements.
  6. In WAIT with CNT == 0: the MEM register loads and the block moves to PASS.
- EX_STALL (combinational) = RESET & (MEM_STALL | (!FLUSH & ((PASS & EX_VALID & is_md & MD_CYCLES!=0) | (WAIT & CNT!=0)))).
- Upstream holds the EX inputs stable while EX_STALL = 1. Inputs are sampled only on a load edge.

## Timing
- Reset (RESET = 0, asynchronous): state is PASS, CNT is 0, and every MEM_* output is 0. EX_STALL is 0 while reset is asserted.
- Base op latency: one edge from EX to the MEM outputs, with no stall.
- M op latency: EX_STALL is high for MD_CYCLES consecutive cycles. The result is captured on the edge ending the (MD_CYCLES+1)th cycle, so it is visible on MEM one cycle after EX_STALL falls.
- MEM_STALL during WAIT freezes CNT. The total stall becomes MD_CYCLES plus the number of MEM_STALL cycles.
- FLUSH during WAIT aborts immediately: EX_STALL drops that same cycle and no M result ever reaches MEM.
- Back-to-back M ops: the second one enters PASS detection on the cycle after the first is captured, so there is no gap bubble beyond its own MD_CYCLES.
- If reset is asserted mid-WAIT, the block returns to PASS with all outputs at 0 at once, without waiting for a clock edge.

## Test plan
- Reset, then an ADD with EX_ALU_RESULT = 0x0000_0010 and rd = 5 -> next edge gives MEM_VALID = 1, MEM_ALU_RESULT = 0x10, MEM_RD_ADDR = 5, and EX_STALL stays 0.
- With MD_CYCLES = 2, a MUL with result 0xFFFF_FFF0 -> EX_STALL is high for exactly 2 cycles and MEM_VALID is 0 for 2 edges. The 3rd edge gives MEM_VALID = 1 and MEM_ALU_RESULT = 0xFFFF_FFF0.
- A DIV in WAIT with FLUSH pulsed at CNT = 1 -> EX_STALL goes to 0 the same cycle, the next edge is a bubble, state is PASS, and the DIV is never visible on MEM.
- A SW (MEM_WRITE = 1, RS2 = 0xDEAD_BEEF) loaded into MEM, then MEM_STALL held for 3 cycles with a new ADD in EX -> the MEM outputs hold the store for all 3 cycles and EX_STALL = 1. The ADD loads on the first edge after MEM_STALL falls.
- RESET asserted asynchronously mid-WAIT -> all MEM_* outputs are 0 immediately and EX_STALL = 0. After release, a REM with MD_CYCLES = 0 flows through in one edge with no stall.
